// File: rtl/dd_puf_pkg.sv
// Shared types and constants for the DD-PUF readout path.
package dd_puf_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned NUM_BYTES  = DATA_W_DEF / 8;
    localparam int unsigned IDX_W      = 5;

    localparam logic [7:0] CRC_POLY_DEF = 8'h07;
    localparam logic [7:0] CRC_INIT_DEF = 8'h00;

    localparam logic [7:0] CMD_START  = 8'd1;
    localparam logic [7:0] CMD_REWIND = 8'd2;
    localparam logic [7:0] CMD_CLEAR  = 8'd3;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_CRC_CALC,
        ST_LOADED,
        ST_STREAM,
        ST_DRAINED
    } state_t;

endpackage

// File: rtl/crc8_step.sv
// One byte of MSB-first CRC-8 (no reflection), fully unrolled.
module crc8_step
    import dd_puf_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY_DEF
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/dd_puf_readout.sv
// Captures the DD-PUF response, computes its CRC-8 and serves it as bytes
// (data MSB-first, then CRC) over a request/valid handshake.
module dd_puf_readout
    import dd_puf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter logic [7:0]  CRC_POLY = CRC_POLY_DEF,
    parameter logic [7:0]  CRC_INIT = CRC_INIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        CODE,
    input  logic              DONE,
    input  logic [DATA_W-1:0] PUF_OUT,
    input  logic              RD_REQ,
    output logic [7:0]        RD_DATA,
    output logic              RD_VALID,
    output logic              DATA_READY,
    output logic              OVERRUN,
    output logic              UNDERRUN
);

    localparam int unsigned    N_BYTES  = DATA_W / 8;
    localparam int unsigned    N_SLOTS  = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] CRC_IDX = IDX_W'(N_BYTES);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         crc_q, crc_d;
    logic [DATA_W-1:0]  data_q;
    logic               done_q;
    logic [7:0]         code_q;

    logic               done_rise_c, clear_c, rewind_c;
    logic               capture_c, serve_c, set_ovr_c, set_und_c;
    logic [7:0]         byte_sel_c, crc_step_c;
    logic [7:0]         data_bytes [N_SLOTS];

    assign done_rise_c = DONE && !done_q;
    assign clear_c     = (CODE == CMD_CLEAR)  && (code_q != CMD_CLEAR);
    assign rewind_c    = (CODE == CMD_REWIND) && (code_q != CMD_REWIND);

    // Byte view of the stored word; slots past the data are never selected.
    always_comb begin
        data_bytes = '{default: 8'h00};
        for (int i = 0; i < int'(N_BYTES); i++) begin
            data_bytes[i] = data_q[DATA_W-1-8*i -: 8];
        end
    end

    assign byte_sel_c = (idx_q < CRC_IDX) ? data_bytes[idx_q] : crc_q;

    crc8_step #(.POLY(CRC_POLY)) u_crc (
        .crc_in  (crc_q),
        .byte_in (byte_sel_c),
        .crc_out (crc_step_c)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Event priority: CLEAR > capture > REWIND > read.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        crc_d     = crc_q;
        capture_c = 1'b0;
        serve_c   = 1'b0;
        set_ovr_c = 1'b0;
        if (clear_c) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
            crc_d   = CRC_INIT;
        end else if (done_rise_c && (state_q == ST_EMPTY || state_q == ST_DRAINED)) begin
            capture_c = 1'b1;
            state_d   = ST_CRC_CALC;
            idx_d     = '0;
            crc_d     = CRC_INIT;
        end else begin
            set_ovr_c = done_rise_c;
            if (rewind_c && (state_q == ST_LOADED || state_q == ST_STREAM
                             || state_q == ST_DRAINED)) begin
                state_d = ST_LOADED;
                idx_d   = '0;
            end else if (state_q == ST_CRC_CALC) begin
                // Extra cycle at CRC_IDX aligns DATA_READY to 17 cycles after capture.
                if (idx_q == CRC_IDX) begin
                    state_d = ST_LOADED;
                    idx_d   = '0;
                end else begin
                    crc_d = crc_step_c;
                    idx_d = idx_q + IDX_W'(1);
                end
            end else if (RD_REQ && (state_q == ST_LOADED || state_q == ST_STREAM)) begin
                serve_c = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == CRC_IDX) ? ST_DRAINED : ST_STREAM;
            end
        end
        set_und_c = RD_REQ && !serve_c;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            idx_q      <= '0;
            crc_q      <= CRC_INIT;
            data_q     <= '0;
            done_q     <= 1'b0;
            code_q     <= 8'h00;
            RD_DATA    <= 8'h00;
            RD_VALID   <= 1'b0;
            DATA_READY <= 1'b0;
            OVERRUN    <= 1'b0;
            UNDERRUN   <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            done_q     <= DONE;
            code_q     <= CODE;
            RD_VALID   <= RD_REQ;
            DATA_READY <= (state_d == ST_LOADED) || (state_d == ST_STREAM);
            if (clear_c)        data_q <= '0;
            else if (capture_c) data_q <= PUF_OUT;
            if (RD_REQ)         RD_DATA <= serve_c ? byte_sel_c : 8'h00;
            // A read losing to CLEAR still reports its underrun.
            OVERRUN  <= clear_c ? 1'b0 : (OVERRUN | set_ovr_c);
            UNDERRUN <= clear_c ? set_und_c : (UNDERRUN | set_und_c);
        end
    end

endmodule

// File: tb/tb_dd_puf_readout.sv
// Directed bench for dd_puf_readout: capture timing, byte stream, CRC, commands, error flags.
module tb_dd_puf_readout;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [7:0]   CODE;
    logic         DONE;
    logic [127:0] PUF_OUT;
    logic         RD_REQ;
    logic [7:0]   RD_DATA;
    logic         RD_VALID;
    logic         DATA_READY;
    logic         OVERRUN;
    logic         UNDERRUN;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] W4 = 128'h00112233445566778899AABBCCDDEEFF;

    always #5 CLK = ~CLK;

    dd_puf_readout dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CODE       (CODE),
        .DONE       (DONE),
        .PUF_OUT    (PUF_OUT),
        .RD_REQ     (RD_REQ),
        .RD_DATA    (RD_DATA),
        .RD_VALID   (RD_VALID),
        .DATA_READY (DATA_READY),
        .OVERRUN    (OVERRUN),
        .UNDERRUN   (UNDERRUN)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-8 reference, poly 0x07, seed 0, MSB first.
    function automatic logic [7:0] crc_ref(input logic [127:0] w);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ w[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rd_data"}, 128'(RD_DATA), 128'(0));
        check({tag, "_rd_valid"}, 128'(RD_VALID), 128'(0));
        check({tag, "_ready"}, 128'(DATA_READY), 128'(0));
        check({tag, "_overrun"}, 128'(OVERRUN), 128'(0));
        check({tag, "_underrun"}, 128'(UNDERRUN), 128'(0));
    endtask

    // Single read: one-cycle request, byte and valid checked one cycle later.
    task automatic rd(input string tag, input logic [7:0] exp);
        RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        check({tag, "_valid"}, 128'(RD_VALID), 128'(1));
        check(tag, 128'(RD_DATA), 128'(exp));
    endtask

    // Capture with DONE held 'hold' cycles; PUF_OUT is scrambled after the edge.
    task automatic capture(input string tag, input logic [127:0] w, input int hold);
        PUF_OUT = w;
        DONE    = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == hold) DONE = 1'b0;
            if (i == 1) PUF_OUT = ~w;
            tick();
        end
        DONE = 1'b0;
        check({tag, "_ready_c16"}, 128'(DATA_READY), 128'(0));
        tick();
        check({tag, "_ready_c17"}, 128'(DATA_READY), 128'(1));
    endtask

    initial begin
        RESET   = 1'b0;
        CODE    = 8'h00;
        DONE    = 1'b0;
        PUF_OUT = '0;
        RD_REQ  = 1'b0;

        // 1: reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            DONE    = ~DONE;
            RD_REQ  = ~RD_REQ;
            PUF_OUT = 128'h1234;
            tick();
            check_idle("t1_in_reset");
        end
        DONE   = 1'b0;
        RD_REQ = 1'b0;
        tick();
        #2 RESET = 1'b1;
        tick();
        check_idle("t1_post_reset");

        // 2: all-zero word, DONE held 3 cycles counts once
        capture("t2", 128'h0, 3);
        for (int i = 0; i < 16; i++) rd("t2_byte", 8'h00);
        check("t2_ready_before_crc", 128'(DATA_READY), 128'(1));
        rd("t2_crc", 8'h00);
        check("t2_ready_fall", 128'(DATA_READY), 128'(0));
        check("t2_overrun", 128'(OVERRUN), 128'(0));
        check("t2_underrun", 128'(UNDERRUN), 128'(0));
        tick();
        check("t2_valid_fall", 128'(RD_VALID), 128'(0));

        // 3: word = 1 captured from DRAINED
        capture("t3", 128'h1, 1);
        for (int i = 0; i < 15; i++) rd("t3_byte", 8'h00);
        rd("t3_byte15", 8'h01);
        rd("t3_crc", 8'h07);
        check("t3_ready_fall", 128'(DATA_READY), 128'(0));

        // 4: partial read, rewind with CODE held, overrun during stream
        capture("t4", W4, 2);
        for (int i = 0; i < 5; i++) rd("t4_byte", 8'(i * 17));
        CODE = 8'd2;
        tick();
        rd("t4_rewind_b0", 8'h00);
        rd("t4_held_code_b1", 8'h11);
        CODE    = 8'h00;
        DONE    = 1'b1;
        PUF_OUT = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        tick();
        DONE = 1'b0;
        check("t4_overrun", 128'(OVERRUN), 128'(1));
        check("t4_ready_kept", 128'(DATA_READY), 128'(1));
        for (int i = 2; i < 16; i++) rd("t4_byte", 8'(i * 17));
        rd("t4_crc", crc_ref(W4));
        check("t4_ready_fall", 128'(DATA_READY), 128'(0));
        check("t4_underrun", 128'(UNDERRUN), 128'(0));

        // 5: CLEAR, then underrun in EMPTY, then CLEAR again
        CODE = 8'd3;
        tick();
        CODE = 8'h00;
        check("t5_clear_overrun", 128'(OVERRUN), 128'(0));
        check("t5_clear_ready", 128'(DATA_READY), 128'(0));
        rd("t5_empty_read", 8'h00);
        check("t5_underrun_set", 128'(UNDERRUN), 128'(1));
        tick();
        check("t5_valid_fall", 128'(RD_VALID), 128'(0));
        CODE = 8'd3;
        tick();
        CODE = 8'h00;
        check("t5_underrun_clr", 128'(UNDERRUN), 128'(0));

        // 6: CLEAR + DONE edge + RD_REQ together in STREAM
        capture("t6", W4, 1);
        rd("t6_b0", 8'h00);
        rd("t6_b1", 8'h11);
        CODE    = 8'd3;
        DONE    = 1'b1;
        RD_REQ  = 1'b1;
        PUF_OUT = 128'h1;
        tick();
        CODE   = 8'h00;
        RD_REQ = 1'b0;
        check("t6_valid", 128'(RD_VALID), 128'(1));
        check("t6_rd_zero", 128'(RD_DATA), 128'(0));
        check("t6_underrun", 128'(UNDERRUN), 128'(1));
        check("t6_overrun", 128'(OVERRUN), 128'(0));
        check("t6_ready", 128'(DATA_READY), 128'(0));
        tick();
        DONE = 1'b0;
        repeat (20) tick();
        check("t6_no_capture", 128'(DATA_READY), 128'(0));
        capture("t6_recap", 128'h1, 1);
        for (int i = 0; i < 15; i++) rd("t6_byte", 8'h00);
        rd("t6_byte15", 8'h01);
        rd("t6_crc", 8'h07);
        check("t6_final_overrun", 128'(OVERRUN), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
